qea_state_readout: RTL



---
 rtl/qea_state_readout.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/qea_state_readout.sv
// qea_state_readout: drains the QEA state RAM once QEA is finished.
// Every complex amplitude a = re + j*im becomes a fixed-point probability |a|^2.
// One stream beat is emitted per state-RAM word, and the stream carries PE_NUM lanes.
// The block also keeps a running sum of everything it has emitted, so software can check normalisation.
module qea_state_readout #(
    parameter int PE_NUM           = 4,
    parameter int PE_NUM_WIDTH     = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int PROB_WIDTH       = 32,
    parameter int RD_LATENCY       = 1,
    parameter int SUM_WIDTH        = PROB_WIDTH + STATE_ADDR_WIDTH + PE_NUM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]      i_qbit_num,
    output logic                           o_state_ena,
    output logic [STATE_ADDR_WIDTH-1:0]    o_state_addra,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] i_state_dout,
    output logic                           o_prob_valid,
    input  logic                           i_prob_ready,
    output logic [STATE_ADDR_WIDTH-1:0]    o_prob_addr,
    output logic [PE_NUM*PROB_WIDTH-1:0]   o_prob_data,
    output logic                           o_prob_last,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic [SUM_WIDTH-1:0]           o_prob_sum
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W      = CNT_W + 2;
    localparam int BEAT_W     = PE_NUM * PROB_WIDTH;
    localparam int ENTRY_W    = BEAT_W + STATE_ADDR_WIDTH + 1;
    localparam int SQ_W       = 2 * DATA_WIDTH + 1;
    localparam int LANE_SUM_W = PROB_WIDTH + PE_NUM_WIDTH;

    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                        state_q;
    logic [STATE_ADDR_WIDTH-1:0]   rd_addr_q;
    logic [STATE_ADDR_WIDTH-1:0]   last_addr_q;
    logic                          err_q;
    logic [SUM_WIDTH-1:0]          sum_q;

    // Read-return tracking: one valid bit plus address per RAM latency stage
    logic [RD_LATENCY-1:0]         pipe_vld_q;
    logic [STATE_ADDR_WIDTH-1:0]   pipe_addr_q [RD_LATENCY];

    // Compute stage holding the squared magnitudes of the word that just returned
    logic                          cmp_vld_q;
    logic [BEAT_W-1:0]             cmp_data_q;
    logic [STATE_ADDR_WIDTH-1:0]   cmp_addr_q;
    logic                          cmp_last_q;

    // Output FIFO
    logic [ENTRY_W-1:0]            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q;
    logic [PTR_W-1:0]              rd_ptr_q;
    logic [CNT_W-1:0]              fifo_cnt_q;

    logic                          qbit_ok;
    logic [MAX_QBIT_WIDTH-1:0]     word_shift;
    logic [STATE_ADDR_WIDTH-1:0]   last_addr_d;
    logic [INF_W-1:0]              pipe_cnt;
    logic [INF_W-1:0]              occupancy;
    logic                          issue;
    logic                          ret_vld;
    logic [STATE_ADDR_WIDTH-1:0]   ret_addr;
    logic [BEAT_W-1:0]             lane_prob;
    logic                          fifo_empty;
    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          out_fire;
    logic [ENTRY_W-1:0]            cmp_entry;
    logic [ENTRY_W-1:0]            out_entry;
    logic [LANE_SUM_W-1:0]         beat_sum;

    // The number of words is a power of two, so the last address is simply a mask of low ones.
    assign qbit_ok     = (i_qbit_num >= QBIT_MIN) && (i_qbit_num <= QBIT_MAX);
    assign word_shift  = i_qbit_num - QBIT_MIN;
    assign last_addr_d = ~({STATE_ADDR_WIDTH{1'b1}} << word_shift);

    // Count every word that still needs a slot: words in the RAM, the compute stage, and the FIFO.
    always_comb begin
        pipe_cnt = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            pipe_cnt = pipe_cnt + INF_W'(pipe_vld_q[k]);
        end
    end

    assign occupancy = pipe_cnt + INF_W'(cmp_vld_q) + INF_W'(fifo_cnt_q);
    assign issue     = (state_q == ST_READ) && (occupancy < INF_W'(FIFO_DEPTH));
    assign ret_vld   = pipe_vld_q[RD_LATENCY-1];
    assign ret_addr  = pipe_addr_q[RD_LATENCY-1];

    // Per-lane |a|^2 with saturation to the probability width
    generate
        for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0]   re;
            logic signed [DATA_WIDTH-1:0]   im;
            logic signed [2*DATA_WIDTH-1:0] re_sq;
            logic signed [2*DATA_WIDTH-1:0] im_sq;
            logic        [SQ_W-1:0]         mag_sq;
            logic        [SQ_W-1:0]         scaled;

            assign re     = i_state_dout[(gi+1)*2*DATA_WIDTH-1 -: DATA_WIDTH];
            assign im     = i_state_dout[gi*2*DATA_WIDTH +: DATA_WIDTH];
            assign re_sq  = re * re;
            assign im_sq  = im * im;
            // Both squares are non-negative, so they can be widened as unsigned values.
            assign mag_sq = {1'b0, re_sq} + {1'b0, im_sq};
            assign scaled = mag_sq >> NUM_FRAC_BIT;
            assign lane_prob[gi*PROB_WIDTH +: PROB_WIDTH] =
                (|scaled[SQ_W-1:PROB_WIDTH]) ? {PROB_WIDTH{1'b1}} : scaled[PROB_WIDTH-1:0];
        end
    endgenerate

    // While the FIFO is empty, the compute stage drives the stream directly, which saves a cycle of latency.
    assign fifo_empty   = (fifo_cnt_q == '0);
    assign cmp_entry    = {cmp_last_q, cmp_addr_q, cmp_data_q};
    assign out_entry    = fifo_empty ? cmp_entry : fifo_mem[rd_ptr_q];
    assign o_prob_valid = cmp_vld_q || !fifo_empty;
    assign o_prob_data  = out_entry[BEAT_W-1:0];
    assign o_prob_addr  = out_entry[BEAT_W +: STATE_ADDR_WIDTH];
    assign o_prob_last  = out_entry[ENTRY_W-1];
    assign out_fire     = o_prob_valid && i_prob_ready;
    assign fifo_pop     = out_fire && !fifo_empty;
    // The compute stage always vacates each cycle, either straight onto the stream or into the FIFO.
    assign fifo_push    = cmp_vld_q && !(fifo_empty && i_prob_ready);

    // Add up all lanes of the beat currently being presented
    always_comb begin
        beat_sum = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            beat_sum = beat_sum + LANE_SUM_W'(o_prob_data[p*PROB_WIDTH +: PROB_WIDTH]);
        end
    end

    assign o_state_ena   = issue;
    assign o_state_addra = rd_addr_q;
    assign o_busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign o_done        = (state_q == ST_DONE);
    assign o_err         = (state_q == ST_DONE) && err_q;
    assign o_prob_sum    = sum_q;

    // Sweep control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        rd_addr_q   <= '0;
                        last_addr_q <= last_addr_d;
                        err_q       <= !qbit_ok;
                        state_q     <= qbit_ok ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                        if (rd_addr_q == last_addr_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last beat is the youngest word, so once it is accepted the whole pipeline is empty.
                    if (out_fire && o_prob_last) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Running probability sum, cleared when a sweep is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            sum_q <= '0;
        end else if (out_fire) begin
            sum_q <= sum_q + SUM_WIDTH'(beat_sum);
        end
    end

    // RAM latency tracker, stage 0
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q[0] <= 1'b0;
        end else begin
            pipe_vld_q[0] <= issue;
        end
        pipe_addr_q[0] <= rd_addr_q;
    end

    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            // RAM latency tracker, later stages
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld_q[gi] <= 1'b0;
                end else begin
                    pipe_vld_q[gi] <= pipe_vld_q[gi-1];
                end
                pipe_addr_q[gi] <= pipe_addr_q[gi-1];
            end
        end
    endgenerate

    // Compute stage: register the lane probabilities of the returning word
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            cmp_data_q <= '0;
            cmp_addr_q <= '0;
            cmp_last_q <= 1'b0;
        end else begin
            cmp_vld_q <= ret_vld;
            if (ret_vld) begin
                cmp_data_q <= lane_prob;
                cmp_addr_q <= ret_addr;
                cmp_last_q <= (ret_addr == last_addr_q);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= cmp_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

endmodule
